// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types for the RISCAT pipeline scoreboard: per-stage tracking entry and forward-select.
// Entry fields are sized for the largest supported configuration (REG_AW <= 8, DEPTH <= 15).
package riscat_pipe_pkg;

  localparam int SB_AW_MAX = 8;
  localparam int SB_LW_MAX = 4;

  typedef logic [SB_LW_MAX-1:0] fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [SB_AW_MAX-1:0] rd;
    logic [SB_LW_MAX-1:0] rem;
  } sb_entry_t;

  localparam fwd_sel_t FWD_REGFILE = '0;

  function automatic logic [SB_LW_MAX-1:0] rem_dec(input logic [SB_LW_MAX-1:0] r);
    return (r == '0) ? '0 : r - SB_LW_MAX'(1);
  endfunction

endpackage

// File: rtl/pipeline_scoreboard_src_match.sv
// Per-source priority search over the in-flight entries; the youngest matching stage decides
// between a forward from that stage, a hazard, or the regfile path.
module scoreboard_src_match import riscat_pipe_pkg::*; #(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_en,
  output logic [LW-1:0]     fwd_sel,
  output logic              hazard
);

  always_comb begin
    fwd_sel = LW'(FWD_REGFILE);
    hazard  = 1'b0;
    if (rs_en && (rs != '0)) begin
      // Walk oldest to youngest so the youngest match overrides (WAW).
      for (int s = DEPTH; s >= 1; s--) begin
        if (entries[s-1].valid && (entries[s-1].rd == SB_AW_MAX'(rs))) begin
          if (entries[s-1].rem == '0) begin
            fwd_sel = LW'(s);
            hazard  = 1'b0;
          end else begin
            fwd_sel = LW'(FWD_REGFILE);
            hazard  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding tracker: shifts in-flight destinations through DEPTH post-issue stages,
// drives per-source forward selects and stalls issue until a needed result exists.
module pipeline_scoreboard import riscat_pipe_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_AW  = 5,
  localparam int LW     = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [LW-1:0]             issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0] issue_rs,
  input  logic [NUM_SRC-1:0]        issue_rs_en,
  output logic                      issue_ready,
  output logic [NUM_SRC*LW-1:0]     fwd_sel,
  input  logic                      flush,
  output logic [31:0]               stall_count
);

  sb_entry_t          entry_q [DEPTH];
  sb_entry_t          entry_d [DEPTH];
  logic [NUM_SRC-1:0] hazard;
  logic [31:0]        stall_count_q;
  logic [31:0]        stall_count_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    scoreboard_src_match #(
      .DEPTH  (DEPTH),
      .REG_AW (REG_AW)
    ) u_match (
      .entries (entry_q),
      .rs      (issue_rs[i*REG_AW +: REG_AW]),
      .rs_en   (issue_rs_en[i]),
      .fwd_sel (fwd_sel[i*LW +: LW]),
      .hazard  (hazard[i])
    );
  end

  assign issue_ready = ~(|hazard) & ~flush;
  assign stall_count = stall_count_q;

  always_comb begin
    entry_d[0].valid = issue_valid & issue_ready & ~flush & (issue_rd != '0);
    entry_d[0].rd    = SB_AW_MAX'(issue_rd);
    entry_d[0].rem   = SB_LW_MAX'(issue_lat) - SB_LW_MAX'(1);
    // Flush kills whatever is leaving stage 1 on this edge; the last stage simply retires.
    for (int s = 1; s < DEPTH; s++) begin
      entry_d[s].valid = entry_q[s-1].valid & ~(flush && (s == 1));
      entry_d[s].rd    = entry_q[s-1].rd;
      entry_d[s].rem   = rem_dec(entry_q[s-1].rem);
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (issue_valid && !issue_ready && !flush && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < DEPTH; s++) entry_q[s] <= '0;
      stall_count_q <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) entry_q[s] <= entry_d[s];
      stall_count_q <= stall_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && issue_valid && issue_ready && (issue_rd != '0))
      assert ((issue_lat != '0) && (int'(issue_lat) <= DEPTH));
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Scoreboard bench: directed and random issue streams on a DEPTH=3/NUM_SRC=2 and a
// DEPTH=5/NUM_SRC=3 instance, checked against an instruction-list reference model.
module tb_pipeline_scoreboard;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       v = 1'b0;
  logic       fl = 1'b0;
  logic [4:0] rd = '0, rs0 = '0, rs1 = '0, rs2 = '0;
  logic [2:0] lat = 3'd1;
  logic [2:0] en = '0;

  logic        a_valid, a_flush, a_ready;
  logic [1:0]  a_lat, a_en;
  logic [9:0]  a_rs;
  logic [3:0]  a_fwd;
  logic [31:0] a_cnt;
  logic        b_valid, b_flush, b_ready;
  logic [2:0]  b_lat, b_en;
  logic [14:0] b_rs;
  logic [8:0]  b_fwd;
  logic [31:0] b_cnt;

  assign a_valid = v & ~sel;
  assign a_flush = fl & ~sel;
  assign a_lat   = lat[1:0];
  assign a_rs    = {rs1, rs0};
  assign a_en    = en[1:0];
  assign b_valid = v & sel;
  assign b_flush = fl & sel;
  assign b_lat   = lat;
  assign b_rs    = {rs2, rs1, rs0};
  assign b_en    = en;

  pipeline_scoreboard #(.NUM_SRC(2), .DEPTH(3), .REG_AW(5)) dut_a (
    .clk(clk), .reset_n(reset_n), .issue_valid(a_valid), .issue_rd(rd), .issue_lat(a_lat),
    .issue_rs(a_rs), .issue_rs_en(a_en), .issue_ready(a_ready), .fwd_sel(a_fwd),
    .flush(a_flush), .stall_count(a_cnt));

  pipeline_scoreboard #(.NUM_SRC(3), .DEPTH(5), .REG_AW(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .issue_valid(b_valid), .issue_rd(rd), .issue_lat(b_lat),
    .issue_rs(b_rs), .issue_rs_en(b_en), .issue_ready(b_ready), .fwd_sel(b_fwd),
    .flush(b_flush), .stall_count(b_cnt));

  // Reference model: accepted instructions with their issue cycle; stage = now - issue cycle.
  typedef struct {int rd; int c; int lat;} inst_t;
  typedef struct packed {logic sel; logic rdy; logic [15:0] fw; logic [31:0] cnt;} exp_t;

  inst_t       fly[$];
  exp_t        sbq[$];
  int          dep = 3, ns = 2, t = 0;
  int unsigned cnt = 0;
  bit          pend_acc, pend_fl, pend_stall, last_rdy;
  int          pend_rd, pend_lat;
  int          n_vec = 0, n_err = 0;

  task automatic eval();
    int   rsv[3];
    int   fw, lw, best, st;
    bit   haz;
    exp_t e;
    rsv = '{int'(rs0), int'(rs1), int'(rs2)};
    lw  = $clog2(dep + 1);
    haz = 1'b0;
    e   = '0;
    for (int i = 0; i < ns; i++) begin
      fw = 0;
      if (en[i] && rsv[i] != 0) begin
        best = -1;
        foreach (fly[k])
          if (fly[k].rd == rsv[i] && (best < 0 || fly[k].c > fly[best].c)) best = k;
        if (best >= 0) begin
          st = t - fly[best].c;
          if (st >= fly[best].lat) fw = st;
          else haz = 1'b1;
        end
      end
      e.fw = e.fw | (16'(fw) << (i * lw));
    end
    e.sel = sel;
    e.rdy = !haz && !fl;
    e.cnt = cnt;
    sbq.push_back(e);
    pend_acc   = v && e.rdy && (rd != 0);
    pend_rd    = int'(rd);
    pend_lat   = int'(lat);
    pend_fl    = fl;
    pend_stall = v && !e.rdy && !fl;
    last_rdy   = e.rdy;
  endtask

  task automatic advance();
    inst_t n;
    if (pend_fl)
      for (int k = fly.size() - 1; k >= 0; k--) if (fly[k].c == t - 1) fly.delete(k);
    if (pend_acc) begin
      n.rd = pend_rd; n.c = t; n.lat = pend_lat;
      fly.push_back(n);
    end
    if (pend_stall && cnt != 32'hFFFF_FFFF) cnt++;
    t++;
    for (int k = fly.size() - 1; k >= 0; k--) if (t - fly[k].c > dep) fly.delete(k);
  endtask

  task automatic clear_model();
    fly.delete();
    cnt = 0;
    pend_acc = 0; pend_fl = 0; pend_stall = 0;
  endtask

  task automatic drive(input bit iv, input int ird, input int ilat, input int irs0,
                       input int irs1, input int irs2, input logic [2:0] ien, input bit ifl);
    @(posedge clk);
    advance();
    #1;
    v = iv; rd = 5'(ird); lat = 3'(ilat);
    rs0 = 5'(irs0); rs1 = 5'(irs1); rs2 = 5'(irs2);
    en = ien; fl = ifl;
    eval();
  endtask

  task automatic do_reset(input bit s);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    v = 1'b0; fl = 1'b0; en = '0; sel = s;
    dep = s ? 5 : 3;
    ns  = s ? 3 : 2;
    clear_model();
    eval();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    eval();
  endtask

  // Reset pulse placed between edges while an instruction is stalled.
  task automatic mid_reset();
    @(posedge clk);
    advance();
    #1;
    reset_n = 1'b0;
    clear_model();
    eval();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic rand_step();
    bit nfl;
    nfl = ($urandom_range(0, 9) == 0);
    if (v && !last_rdy)
      drive(v, int'(rd), int'(lat), int'(rs0), int'(rs1), int'(rs2), en, nfl);
    else
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(1, dep)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            3'($urandom), nfl);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t        e;
      logic        r_act;
      logic [15:0] f_act;
      logic [31:0] c_act;
      e     = sbq.pop_front();
      r_act = e.sel ? b_ready : a_ready;
      f_act = e.sel ? 16'(b_fwd) : 16'(a_fwd);
      c_act = e.sel ? b_cnt : a_cnt;
      n_vec++;
      if (r_act !== e.rdy) begin
        n_err++;
        $display("FAIL issue_ready cyc=%0d dut=%0d got %b want %b", t, e.sel, r_act, e.rdy);
      end
      n_vec++;
      if (f_act !== e.fw) begin
        n_err++;
        $display("FAIL fwd_sel cyc=%0d dut=%0d got %h want %h", t, e.sel, f_act, e.fw);
      end
      n_vec++;
      if (c_act !== e.cnt) begin
        n_err++;
        $display("FAIL stall_count cyc=%0d dut=%0d got %0d want %0d", t, e.sel, c_act, e.cnt);
      end
    end
  end

  initial begin
    do_reset(1'b0);
    // forwarding from each stage, then regfile
    drive(1, 5, 1, 0, 0, 0, 3'b000, 0);
    repeat (4) drive(1, 0, 1, 5, 0, 0, 3'b001, 0);
    // load-use stall
    drive(1, 7, 2, 0, 0, 0, 3'b000, 0);
    repeat (2) drive(1, 0, 1, 0, 7, 0, 3'b010, 0);
    // WAW: youngest wins
    drive(1, 3, 1, 0, 0, 0, 3'b000, 0);
    drive(1, 3, 1, 0, 0, 0, 3'b000, 0);
    drive(1, 0, 1, 3, 0, 0, 3'b001, 0);
    // x0 source and disabled source with a pending writer of r9
    drive(1, 9, 3, 0, 0, 0, 3'b000, 0);
    drive(1, 0, 1, 0, 9, 0, 3'b001, 0);
    // flush kills stage-1 entry; flush blocks issue without counting a stall
    drive(1, 4, 2, 0, 0, 0, 3'b000, 0);
    drive(1, 0, 1, 4, 0, 0, 3'b001, 1);
    drive(1, 0, 1, 4, 0, 0, 3'b001, 0);
    drive(0, 0, 1, 0, 0, 0, 3'b000, 1);
    // async reset mid-stall
    drive(1, 7, 3, 0, 0, 0, 3'b000, 0);
    drive(1, 0, 1, 7, 0, 0, 3'b001, 0);
    mid_reset();
    drive(1, 0, 1, 7, 0, 0, 3'b001, 0);
    repeat (400) rand_step();
    do_reset(1'b1);
    repeat (1500) rand_step();
    repeat (3) @(posedge clk);
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d left want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
